// File: rtl/fir_axil_master.sv
// AXI-Lite initiator for the FIR configuration slave. It issues a single write,
// a single read, or a masked poll-until-match read, and answers each command with one response.
module fir_axil_master #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 64,
    parameter int pPOLL_GAP   = 4,
    parameter int pPOLL_MAX   = 255
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic                   cmd_poll,
    input  logic [pADDR_WIDTH-1:0] cmd_addr,
    input  logic [pDATA_WIDTH-1:0] cmd_wdata,
    input  logic [pDATA_WIDTH-1:0] cmd_mask,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [pDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   awready,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   wready,
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    output logic                   rready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata
);
    localparam int TW = $clog2(pTIMEOUT) + 1;
    localparam int GW = $clog2(pPOLL_GAP) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(pTIMEOUT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(pPOLL_GAP - 1);
    localparam logic [8:0]    P_MAX  = 9'(pPOLL_MAX);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_GAP, S_RESP} state_t;

    state_t                 state, state_nxt;
    logic                   poll, poll_nxt;
    logic [pDATA_WIDTH-1:0] match, match_nxt;
    logic [pDATA_WIDTH-1:0] mask, mask_nxt;
    logic [TW-1:0]          tcnt, tcnt_nxt;
    logic [7:0]             pcnt, pcnt_nxt;
    logic [GW-1:0]          gcnt, gcnt_nxt;
    logic                   aw_done, aw_done_nxt;
    logic                   w_done, w_done_nxt;
    logic                   ar_done, ar_done_nxt;
    logic                   r_done, r_done_nxt;

    logic                   cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [pDATA_WIDTH-1:0] rsp_rdata_nxt, wdata_nxt;
    logic                   awvalid_nxt, wvalid_nxt, arvalid_nxt, rready_nxt;
    logic [pADDR_WIDTH-1:0] awaddr_nxt, araddr_nxt;

    logic                   aw_hs, w_hs, ar_hs, r_hs;
    logic [pDATA_WIDTH-1:0] rd_val;
    logic                   hit;

    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign ar_hs  = arvalid & arready;
    assign r_hs   = rready & rvalid;
    // The read data may have been captured on an earlier cycle than the ar handshake.
    assign rd_val = r_hs ? rdata : rsp_rdata;
    assign hit    = ((rd_val ^ match) & mask) == '0;

    always_comb begin
        state_nxt     = state;
        poll_nxt      = poll;
        match_nxt     = match;
        mask_nxt      = mask;
        tcnt_nxt      = tcnt;
        pcnt_nxt      = pcnt;
        gcnt_nxt      = gcnt;
        aw_done_nxt   = aw_done;
        w_done_nxt    = w_done;
        ar_done_nxt   = ar_done;
        r_done_nxt    = r_done;
        cmd_ready_nxt = 1'b0;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        awvalid_nxt   = awvalid;
        awaddr_nxt    = awaddr;
        wvalid_nxt    = wvalid;
        wdata_nxt     = wdata;
        arvalid_nxt   = arvalid;
        araddr_nxt    = araddr;
        rready_nxt    = rready;

        case (state)
            S_IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_nxt = 1'b0;
                    poll_nxt      = cmd_poll & ~cmd_write;
                    match_nxt     = cmd_wdata;
                    mask_nxt      = cmd_mask;
                    tcnt_nxt      = '0;
                    pcnt_nxt      = '0;
                    aw_done_nxt   = 1'b0;
                    w_done_nxt    = 1'b0;
                    ar_done_nxt   = 1'b0;
                    r_done_nxt    = 1'b0;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b0;
                    if (cmd_write) begin
                        state_nxt   = S_WR;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        awaddr_nxt  = cmd_addr;
                        wdata_nxt   = cmd_wdata;
                    end else begin
                        state_nxt   = S_RD;
                        arvalid_nxt = 1'b1;
                        rready_nxt  = 1'b1;
                        araddr_nxt  = cmd_addr;
                    end
                end
            end

            S_WR: begin
                tcnt_nxt    = tcnt + 1'b1;
                aw_done_nxt = aw_done | aw_hs;
                w_done_nxt  = w_done | w_hs;
                if (aw_hs) awvalid_nxt = 1'b0;
                if (w_hs)  wvalid_nxt  = 1'b0;
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt     = S_RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b0;
                end else if (tcnt == T_LAST) begin
                    state_nxt     = S_RESP;
                    awvalid_nxt   = 1'b0;
                    wvalid_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                end
            end

            S_RD: begin
                tcnt_nxt    = tcnt + 1'b1;
                ar_done_nxt = ar_done | ar_hs;
                r_done_nxt  = r_done | r_hs;
                if (ar_hs) arvalid_nxt = 1'b0;
                if (r_hs) begin
                    rready_nxt    = 1'b0;
                    rsp_rdata_nxt = rdata;
                end
                if ((ar_done || ar_hs) && (r_done || r_hs)) begin
                    arvalid_nxt   = 1'b0;
                    rready_nxt    = 1'b0;
                    rsp_rdata_nxt = rd_val;
                    if (!poll || hit) begin
                        state_nxt     = S_RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b0;
                    end else if (({1'b0, pcnt} + 9'd1) == P_MAX) begin
                        state_nxt     = S_RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_GAP;
                        pcnt_nxt  = pcnt + 8'd1;
                        gcnt_nxt  = '0;
                    end
                end else if (tcnt == T_LAST) begin
                    state_nxt     = S_RESP;
                    arvalid_nxt   = 1'b0;
                    rready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                end
            end

            S_GAP: begin
                if (gcnt == G_LAST) begin
                    state_nxt   = S_RD;
                    arvalid_nxt = 1'b1;
                    rready_nxt  = 1'b1;
                    tcnt_nxt    = '0;
                    ar_done_nxt = 1'b0;
                    r_done_nxt  = 1'b0;
                end else begin
                    gcnt_nxt = gcnt + 1'b1;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt     = S_IDLE;
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state     <= S_IDLE;
            poll      <= 1'b0;
            match     <= '0;
            mask      <= '0;
            tcnt      <= '0;
            pcnt      <= '0;
            gcnt      <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            ar_done   <= 1'b0;
            r_done    <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            arvalid   <= 1'b0;
            araddr    <= '0;
            rready    <= 1'b0;
        end else begin
            state     <= state_nxt;
            poll      <= poll_nxt;
            match     <= match_nxt;
            mask      <= mask_nxt;
            tcnt      <= tcnt_nxt;
            pcnt      <= pcnt_nxt;
            gcnt      <= gcnt_nxt;
            aw_done   <= aw_done_nxt;
            w_done    <= w_done_nxt;
            ar_done   <= ar_done_nxt;
            r_done    <= r_done_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            awvalid   <= awvalid_nxt;
            awaddr    <= awaddr_nxt;
            wvalid    <= wvalid_nxt;
            wdata     <= wdata_nxt;
            arvalid   <= arvalid_nxt;
            araddr    <= araddr_nxt;
            rready    <= rready_nxt;
        end
    end

endmodule

// File: tb/tb_fir_axil_master.sv
// Directed bench for fir_axil_master: writes in both handshake orders, reads, polls,
// timeouts, the poll limit, mid-transaction reset, and response back-pressure.
module tb_fir_axil_master;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          axis_clk, axis_rst_n;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_poll;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata, cmd_mask;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          awvalid, awready, wvalid, wready, arvalid, arready, rready, rvalid;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata, rdata;

    int n_cmp    = 0;
    int n_err    = 0;
    int ar_count = 0;
    int idle;
    int base;

    fir_axil_master #(
        .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pTIMEOUT(16), .pPOLL_GAP(4), .pPOLL_MAX(3)
    ) dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_poll(cmd_poll), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rready(rready), .rvalid(rvalid), .rdata(rdata)
    );

    initial begin
        axis_clk = 1'b0;
        forever #5 axis_clk = ~axis_clk;
    end

    always @(posedge axis_clk) begin
        if (axis_rst_n && arvalid && arready) ar_count = ar_count + 1;
    end

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic pl, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [DW-1:0] msk);
        int n;
        cmd_write = wr;
        cmd_poll  = pl;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_mask  = msk;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("cmd_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Slave answers a read with arready and rvalid together; counts arvalid-low cycles before it.
    task automatic serveRead(input logic [DW-1:0] val, output int gap);
        gap = 0;
        while (!arvalid && gap < 40) begin
            tick();
            gap++;
        end
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = val;
        tick();
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
    endtask

    task automatic consumeRsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        axis_rst_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_poll = 0; cmd_addr = '0; cmd_wdata = '0; cmd_mask = '0;
        rsp_ready = 0; awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;

        // Reset state
        tick(); tick();
        checkOutput("reset_ctrl", {25'd0, cmd_ready, rsp_valid, rsp_err, awvalid, wvalid, arvalid, rready}, 0);
        checkOutput("reset_rdata", rsp_rdata, 0);
        checkOutput("reset_addr", {8'd0, awaddr, araddr}, 0);
        checkOutput("reset_wdata", wdata, 0);
        axis_rst_n = 1'b1;
        tick();
        checkOutput("idle_cmd_ready", cmd_ready, 1);

        // Write, aw handshake first then w three cycles later
        applyStimulus(1'b1, 1'b0, 12'h020, 32'h5, 32'h0);
        checkOutput("wr_valids", {awvalid, wvalid}, 2'b11);
        checkOutput("wr_awaddr", awaddr, 32'h20);
        checkOutput("wr_wdata", wdata, 32'h5);
        checkOutput("wr_cmd_ready_low", cmd_ready, 0);
        tick();
        awready = 1'b1;
        tick();
        awready = 1'b0;
        checkOutput("wr_aw_drop", {awvalid, wvalid}, 2'b01);
        tick(); tick();
        checkOutput("wr_w_hold", {wvalid, rsp_valid}, 2'b10);
        checkOutput("wr_w_data_hold", wdata, 32'h5);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        checkOutput("wr_w_drop", wvalid, 0);
        checkOutput("wr_rsp", {rsp_valid, rsp_err}, 2'b10);
        checkOutput("wr_rdata", rsp_rdata, 0);
        consumeRsp();
        checkOutput("wr_done", {cmd_ready, rsp_valid}, 2'b10);

        // Write, w handshake before aw
        applyStimulus(1'b1, 1'b0, 12'h024, 32'h7, 32'h0);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        checkOutput("wr2_w_first", {awvalid, wvalid, rsp_valid}, 3'b100);
        tick();
        checkOutput("wr2_aw_hold", {awvalid, rsp_valid}, 2'b10);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        checkOutput("wr2_rsp", {awvalid, rsp_valid, rsp_err}, 3'b010);
        consumeRsp();

        // Read with late arready and later rvalid, then response back-pressure
        base = ar_count;
        applyStimulus(1'b0, 1'b0, 12'h010, 32'h0, 32'h0);
        checkOutput("rd_start", {arvalid, rready}, 2'b11);
        checkOutput("rd_araddr", araddr, 32'h10);
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checkOutput("rd_ar_drop", {arvalid, rready}, 2'b01);
        tick();
        rvalid = 1'b1;
        rdata  = 32'h258;
        tick();
        rvalid = 1'b0;
        rdata  = '0;
        checkOutput("rd_rready_drop", rready, 0);
        checkOutput("rd_rsp", {rsp_valid, rsp_err}, 2'b10);
        checkOutput("rd_rdata", rsp_rdata, 32'h258);
        checkOutput("rd_ar_count", ar_count - base, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall_valid", {rsp_valid, cmd_ready}, 2'b10);
            checkOutput("stall_rdata", rsp_rdata, 32'h258);
        end
        consumeRsp();
        checkOutput("stall_release", {cmd_ready, rsp_valid}, 2'b10);

        // Poll that hits on the third read
        base = ar_count;
        applyStimulus(1'b0, 1'b1, 12'h000, 32'h2, 32'h2);
        serveRead(32'h4, idle);
        checkOutput("poll_miss1", rsp_valid, 0);
        serveRead(32'h4, idle);
        checkOutput("poll_gap1", (idle >= 4), 1);
        serveRead(32'h6, idle);
        checkOutput("poll_gap2", (idle >= 4), 1);
        checkOutput("poll_rsp", {rsp_valid, rsp_err}, 2'b10);
        checkOutput("poll_rdata", rsp_rdata, 32'h6);
        checkOutput("poll_reads", ar_count - base, 3);
        consumeRsp();

        // Read timeout with arready never asserted
        applyStimulus(1'b0, 1'b0, 12'h018, 32'h0, 32'h0);
        repeat (15) tick();
        checkOutput("to_pending", {arvalid, rready, rsp_valid}, 3'b110);
        tick();
        checkOutput("to_drop", {arvalid, rready}, 0);
        checkOutput("to_rsp", {rsp_valid, rsp_err}, 2'b11);
        consumeRsp();

        // Poll limit reached with a slave that never matches
        base = ar_count;
        applyStimulus(1'b0, 1'b1, 12'h000, 32'h2, 32'h2);
        serveRead(32'h4, idle);
        serveRead(32'h4, idle);
        checkOutput("plim_miss2", rsp_valid, 0);
        serveRead(32'h4, idle);
        checkOutput("plim_rsp", {rsp_valid, rsp_err}, 2'b11);
        checkOutput("plim_rdata", rsp_rdata, 32'h4);
        checkOutput("plim_reads", ar_count - base, 3);
        checkOutput("plim_no_more", arvalid, 0);
        consumeRsp();

        // Reset asserted mid-write
        applyStimulus(1'b1, 1'b0, 12'h030, 32'h9, 32'h0);
        checkOutput("rst_pre", awvalid, 1);
        #2 axis_rst_n = 1'b0;
        #1;
        checkOutput("rst_async", {26'd0, cmd_ready, rsp_valid, awvalid, wvalid, arvalid, rready}, 0);
        checkOutput("rst_async_awaddr", awaddr, 0);
        checkOutput("rst_async_wdata", wdata, 0);
        tick(); tick();
        checkOutput("rst_no_rsp", rsp_valid, 0);
        axis_rst_n = 1'b1;
        tick();
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        applyStimulus(1'b0, 1'b0, 12'h014, 32'h0, 32'h0);
        serveRead(32'hABCD, idle);
        checkOutput("rst_read_rsp", {rsp_valid, rsp_err}, 2'b10);
        checkOutput("rst_read_rdata", rsp_rdata, 32'hABCD);
        consumeRsp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
